// File: rtl/program_loader.sv
// Host-side program loader: parses a framed byte stream into 16-bit memory writes
// for the core's instruction/data memories, then runs the core until it halts.
module program_loader (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        cpu_done,
    output logic        test_normal,
    output logic        cpu_clr,
    output logic        ext_instr_we,
    output logic [15:0] ext_instr_addr,
    output logic [15:0] ext_instr_data,
    output logic        ext_data_we,
    output logic [15:0] ext_data_addr,
    output logic [15:0] ext_data_data,
    output logic        busy,
    output logic        err,
    output logic        run_done,
    output logic [31:0] run_cycles
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_CNT_H,
        S_CNT_L,
        S_DATA_H,
        S_DATA_L,
        S_WRITE,
        S_RUN_RST,
        S_RUN
    } state_t;

    localparam logic [7:0] HDR_INSTR = 8'hA5;
    localparam logic [7:0] HDR_DATA  = 8'h5A;
    localparam logic [7:0] HDR_RUN   = 8'h3C;

    state_t      state;
    logic        tgt_instr;
    logic [15:0] addr_p0;
    logic [15:0] remain_p0;
    logic [7:0]  addr_h_p0;
    logic [7:0]  cnt_h_p0;
    logic [7:0]  data_h_p0;
    logic        vld_p0;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        case (state)
            S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L:
                in_ready = ~clr;
            default:
                in_ready = 1'b0;
        endcase
    end

    assign vld_p0 = in_valid & in_ready;

    // Field bytes land in staging registers; the write strobe fires one cycle after DATA_L
    always_ff @(posedge clk) begin
        if (clr) begin
            state          <= S_IDLE;
            tgt_instr      <= 1'b0;
            test_normal    <= 1'b0;
            cpu_clr        <= 1'b0;
            ext_instr_we   <= 1'b0;
            ext_instr_addr <= 16'h0000;
            ext_instr_data <= 16'h0000;
            ext_data_we    <= 1'b0;
            ext_data_addr  <= 16'h0000;
            ext_data_data  <= 16'h0000;
            busy           <= 1'b0;
            err            <= 1'b0;
            run_done       <= 1'b0;
            run_cycles     <= 32'h0000_0000;
        end else begin
            ext_instr_we <= 1'b0;
            ext_data_we  <= 1'b0;
            cpu_clr      <= 1'b0;
            run_done     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (vld_p0) begin
                        case (in_data)
                            HDR_INSTR: begin
                                tgt_instr <= 1'b1;
                                state     <= S_ADDR_H;
                                busy      <= 1'b1;
                            end
                            HDR_DATA: begin
                                tgt_instr <= 1'b0;
                                state     <= S_ADDR_H;
                                busy      <= 1'b1;
                            end
                            HDR_RUN: begin
                                state       <= S_RUN_RST;
                                busy        <= 1'b1;
                                test_normal <= 1'b1;
                                cpu_clr     <= 1'b1;
                                run_cycles  <= 32'h0000_0000;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end

                S_ADDR_H: begin
                    if (vld_p0) begin
                        addr_h_p0 <= in_data;
                        state     <= S_ADDR_L;
                    end
                end

                S_ADDR_L: begin
                    if (vld_p0) begin
                        addr_p0 <= {addr_h_p0, in_data};
                        state   <= S_CNT_H;
                    end
                end

                S_CNT_H: begin
                    if (vld_p0) begin
                        cnt_h_p0 <= in_data;
                        state    <= S_CNT_L;
                    end
                end

                S_CNT_L: begin
                    if (vld_p0) begin
                        if ({cnt_h_p0, in_data} == 16'h0000) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            remain_p0 <= {cnt_h_p0, in_data};
                            state     <= S_DATA_H;
                        end
                    end
                end

                S_DATA_H: begin
                    if (vld_p0) begin
                        data_h_p0 <= in_data;
                        state     <= S_DATA_L;
                    end
                end

                S_DATA_L: begin
                    if (vld_p0) begin
                        state <= S_WRITE;
                        if (tgt_instr) begin
                            ext_instr_we   <= 1'b1;
                            ext_instr_addr <= addr_p0;
                            ext_instr_data <= {data_h_p0, in_data};
                        end else begin
                            ext_data_we   <= 1'b1;
                            ext_data_addr <= addr_p0;
                            ext_data_data <= {data_h_p0, in_data};
                        end
                    end
                end

                S_WRITE: begin
                    addr_p0   <= addr_p0 + 16'd1;
                    remain_p0 <= remain_p0 - 16'd1;
                    if (remain_p0 == 16'd1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_DATA_H;
                    end
                end

                S_RUN_RST: begin
                    state <= S_RUN;
                end

                // The cycle in which halt is sampled still counts toward run_cycles
                S_RUN: begin
                    run_cycles <= sat_inc32(run_cycles);
                    if (!cpu_done) begin
                        run_done    <= 1'b1;
                        test_normal <= 1'b0;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    test_normal <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a frame-level byte-buffer model predicts every
// output each cycle, and literal expectations pin the directed scenarios.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        cpu_done = 1'b1;
    logic        in_ready;
    logic        test_normal;
    logic        cpu_clr;
    logic        ext_instr_we;
    logic [15:0] ext_instr_addr;
    logic [15:0] ext_instr_data;
    logic        ext_data_we;
    logic [15:0] ext_data_addr;
    logic [15:0] ext_data_data;
    logic        busy;
    logic        err;
    logic        run_done;
    logic [31:0] run_cycles;

    program_loader dut (
        .clk            (clk),
        .clr            (clr),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .cpu_done       (cpu_done),
        .test_normal    (test_normal),
        .cpu_clr        (cpu_clr),
        .ext_instr_we   (ext_instr_we),
        .ext_instr_addr (ext_instr_addr),
        .ext_instr_data (ext_instr_data),
        .ext_data_we    (ext_data_we),
        .ext_data_addr  (ext_data_addr),
        .ext_data_data  (ext_data_data),
        .busy           (busy),
        .err            (err),
        .run_done       (run_done),
        .run_cycles     (run_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  frame[$];
    bit          m_write = 0;
    bit          m_frame_end = 0;
    int          m_run = 0;
    bit          armed = 0;
    logic        e_tn = 0, e_cclr = 0, e_iwe = 0, e_dwe = 0, e_busy = 0, e_err = 0, e_rd = 0;
    logic [15:0] e_ia = 0, e_id = 0, e_da = 0, e_dd = 0;
    logic [31:0] e_rc = 0;

    task automatic model_accept(input logic [7:0] b);
        int          k;
        logic [15:0] cnt;
        logic [15:0] a;
        logic [15:0] w;
        if (frame.size() == 0) begin
            if (b == 8'hA5 || b == 8'h5A) frame.push_back(b);
            else if (b == 8'h3C) begin
                m_run = 1; e_tn = 1; e_cclr = 1; e_rc = 0;
            end else e_err = 1;
        end else begin
            frame.push_back(b);
            if (frame.size() == 5) begin
                cnt = {frame[3], frame[4]};
                if (cnt == 16'd0) frame.delete();
            end else if (frame.size() > 5 && (frame.size() % 2) == 1) begin
                cnt = {frame[3], frame[4]};
                k = (frame.size() - 5) / 2 - 1;
                a = {frame[1], frame[2]} + 16'(k);
                w = {frame[frame.size() - 2], frame[frame.size() - 1]};
                m_write = 1;
                m_frame_end = ((k + 1) == int'(cnt));
                if (frame[0] == 8'hA5) begin
                    e_iwe = 1; e_ia = a; e_id = w;
                end else begin
                    e_dwe = 1; e_da = a; e_dd = w;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (clr) begin
            armed = 1;
            frame.delete();
            m_write = 0; m_frame_end = 0; m_run = 0;
            e_tn = 0; e_cclr = 0; e_iwe = 0; e_dwe = 0; e_busy = 0; e_err = 0; e_rd = 0;
            e_ia = 0; e_id = 0; e_da = 0; e_dd = 0; e_rc = 0;
        end else begin
            e_iwe = 0; e_dwe = 0; e_cclr = 0; e_rd = 0;
            if (m_write) begin
                m_write = 0;
                if (m_frame_end) frame.delete();
            end else if (m_run == 1) begin
                m_run = 2;
            end else if (m_run == 2) begin
                e_rc = (e_rc == 32'hFFFF_FFFF) ? e_rc : e_rc + 32'd1;
                if (!cpu_done) begin
                    m_run = 0; e_rd = 1; e_tn = 0;
                end
            end else if (in_valid) begin
                model_accept(in_data);
            end
            e_busy = (frame.size() != 0) || m_write || (m_run != 0);
        end
    end

    // ---------------- compare + observation log ----------------
    logic [31:0] ilog[$];
    logic [31:0] dlog[$];
    int          n_rd = 0;
    int          n_cclr = 0;
    logic [31:0] rc_at_done = 0;

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready",       in_ready,       !clr && !m_write && (m_run == 0));
            check("test_normal",    test_normal,    e_tn);
            check("cpu_clr",        cpu_clr,        e_cclr);
            check("ext_instr_we",   ext_instr_we,   e_iwe);
            check("ext_instr_addr", ext_instr_addr, e_ia);
            check("ext_instr_data", ext_instr_data, e_id);
            check("ext_data_we",    ext_data_we,    e_dwe);
            check("ext_data_addr",  ext_data_addr,  e_da);
            check("ext_data_data",  ext_data_data,  e_dd);
            check("busy",           busy,           e_busy);
            check("err",            err,            e_err);
            check("run_done",       run_done,       e_rd);
            check("run_cycles",     run_cycles,     e_rc);
            if (ext_instr_we === 1'b1) ilog.push_back({ext_instr_addr, ext_instr_data});
            if (ext_data_we === 1'b1)  dlog.push_back({ext_data_addr, ext_data_data});
            if (run_done === 1'b1) begin
                n_rd++;
                rc_at_done = run_cycles;
            end
            if (cpu_clr === 1'b1) n_cclr++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done) begin
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
            end
            #1;
            done = (in_valid === 1'b1) && (in_ready === 1'b1);
            @(posedge clk); #2;
            n++;
            if (!done && n > 200) begin
                n_checks++;
                $display("FAIL accept_timeout: byte 0x%0h not accepted, in_ready=%b", b, in_ready);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_str(input logic [127:0] v, input int n, input int gap_pct);
        for (int i = 0; i < n; i++) send_byte(v[8 * (n - 1 - i) +: 8], gap_pct);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int          cnt0, cnt1;
    int          kind, wc, gap, nb, cyc;
    logic [15:0] base;
    logic [7:0]  hb, bb;

    initial begin
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        clr = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_run_cycles", run_cycles, 32'h0);
        check("rst_test_normal", test_normal, 1'b0);

        // two-word instruction load
        ilog.delete(); dlog.delete();
        send_str(128'hA5_00_10_00_02_12_34_AB_CD, 9, 0);
        idle(3);
        check("s1_nwrites", ilog.size(), 2);
        check("s1_w0", ilog[0], 32'h0010_1234);
        check("s1_w1", ilog[1], 32'h0011_ABCD);
        check("s1_no_data_we", dlog.size(), 0);
        check("s1_busy_done", busy, 1'b0);

        // data load wrapping the address
        ilog.delete(); dlog.delete();
        send_str(128'h5A_FF_FF_00_02_00_01_00_02, 9, 0);
        idle(3);
        check("s2_nwrites", dlog.size(), 2);
        check("s2_w0", dlog[0], 32'hFFFF_0001);
        check("s2_w1", dlog[1], 32'h0000_0002);

        // zero-count frame, then bad header and sticky err
        ilog.delete(); dlog.delete();
        send_str(128'h5A_00_00_00_00, 5, 0);
        check("s3_idle_after_zero", busy, 1'b0);
        check("s3_ready_after_zero", in_ready, 1'b1);
        send_byte(8'h77, 0);
        check("s3_err_set", err, 1'b1);
        send_str(128'hA5_00_40_00_01_BE_EF, 7, 0);
        idle(2);
        check("s3_err_sticky", err, 1'b1);
        check("s3_nwrites", ilog.size() + dlog.size(), 1);
        pulse_clr();
        check("s3_err_cleared", err, 1'b0);

        // run: 10 busy cycles then halt
        cnt0 = n_rd; cnt1 = n_cclr;
        send_byte(8'h3C, 0);
        cpu_done = 1'b1;
        repeat (11) @(posedge clk);
        #2;
        cpu_done = 1'b0;
        idle(3);
        cpu_done = 1'b1;
        check("s4_run_done_once", n_rd - cnt0, 1);
        check("s4_cpu_clr_once", n_cclr - cnt1, 1);
        check("s4_run_cycles", rc_at_done, 32'd11);
        check("s4_test_normal_off", test_normal, 1'b0);

        // run: halt already in the first RUN cycle
        send_byte(8'h3C, 0);
        cpu_done = 1'b0;
        idle(4);
        cpu_done = 1'b1;
        check("s4b_run_cycles", rc_at_done, 32'd1);

        // four-word frame with a stuttering valid
        ilog.delete();
        send_str(128'hA5_01_00_00_04_11_11_22_22_33_33_44_44, 13, 50);
        idle(3);
        check("s5_nwrites", ilog.size(), 4);
        check("s5_w0", ilog[0], 32'h0100_1111);
        check("s5_w1", ilog[1], 32'h0101_2222);
        check("s5_w2", ilog[2], 32'h0102_3333);
        check("s5_w3", ilog[3], 32'h0103_4444);

        // reset between DATA_H and DATA_L
        ilog.delete();
        send_str(128'hA5_00_20_00_01_55, 6, 0);
        pulse_clr();
        check("s6_busy", busy, 1'b0);
        check("s6_instr_addr", ext_instr_addr, 16'h0);
        check("s6_instr_data", ext_instr_data, 16'h0);
        idle(4);
        check("s6_no_write", ilog.size(), 0);

        // reset during RUN
        cnt0 = n_rd;
        send_byte(8'h3C, 0);
        idle(4);
        pulse_clr();
        cpu_done = 1'b0;
        check("s6b_test_normal", test_normal, 1'b0);
        check("s6b_run_cycles", run_cycles, 32'h0);
        check("s6b_busy", busy, 1'b0);
        idle(4);
        cpu_done = 1'b1;
        check("s6b_no_run_done", n_rd - cnt0, 0);

        // randomized traffic
        for (int f = 0; f < 80; f++) begin
            kind = int'($urandom_range(0, 9));
            gap  = ($urandom_range(0, 1) == 1) ? 40 : 0;
            if (kind < 5) begin
                hb   = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'h5A;
                base = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
                wc   = int'($urandom_range(0, 4));
                send_byte(hb, gap);
                send_byte(base[15:8], gap);
                send_byte(base[7:0], gap);
                send_byte(8'h00, gap);
                send_byte(8'(wc), gap);
                for (int w = 0; w < 2 * wc; w++) send_byte(8'($urandom), gap);
            end else if (kind < 7) begin
                send_byte(8'h3C, gap);
                cyc = 0;
                while (busy === 1'b1 && cyc < 80) begin
                    cpu_done = (cyc > 40) ? 1'b0 : ($urandom_range(0, 5) != 0);
                    @(posedge clk); #2;
                    cyc++;
                end
                cpu_done = 1'b1;
                check("rnd_run_exit", busy, 1'b0);
            end else if (kind == 7) begin
                bb = 8'($urandom);
                if (bb == 8'hA5 || bb == 8'h5A || bb == 8'h3C) bb = 8'h00;
                send_byte(bb, gap);
            end else if (kind == 8) begin
                nb = int'($urandom_range(1, 6));
                send_byte(($urandom_range(0, 1) == 1) ? 8'hA5 : 8'h5A, gap);
                for (int i = 1; i < nb; i++) send_byte((i == 4) ? 8'h03 : 8'($urandom), gap);
                pulse_clr();
            end else begin
                idle(int'($urandom_range(1, 5)));
            end
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side loader that drives the core's external memory-load and control pins. It receives a framed byte stream over a valid/ready handshake and writes 16-bit words into instruction or data memory through the `ext_instr_*` / `ext_data_*` ports. On command it switches the core to normal mode, resets it, and waits for halt. It sits beside the single-cycle core at the top level, between the host link and the core's test/load interface.

## Interface
Parameters:
- none (all widths fixed: 16-bit address/data, 8-bit stream, 32-bit cycle counter)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  stream byte valid
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader can accept a byte
- `cpu_done`  in  1  core's `done` output; 0 = core halted
- `test_normal`  out  1  to core: 0 = test/load mode, 1 = normal execution
- `cpu_clr`  out  1  to core `clr`; one-cycle pulse at run start
- `ext_instr_we`  out  1  instruction-memory write strobe
- `ext_instr_addr`  out  16  instruction-memory write address
- `ext_instr_data`  out  16  instruction-memory write data
- `ext_data_we`  out  1  data-memory write strobe
- `ext_data_addr`  out  16  data-memory write address
- `ext_data_data`  out  16  data-memory write data
- `busy`  out  1  state other than IDLE
- `err`  out  1  sticky bad-header flag
- `run_done`  out  1  one-cycle pulse when the core halts after RUN
- `run_cycles`  out  32  cycles spent in RUN, saturating

## Operation
- A byte is accepted on an edge where `in_valid & in_ready`. `in_ready` = 1 in IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L; 0 in WRITE, RUN_RST, RUN, and while `clr` is asserted.
- Frame header byte, accepted in IDLE:
  - 0xA5 selects the instruction target and goes to ADDR_H.
  - 0x5A selects the data target and goes to ADDR_H.
  - 0x3C goes to RUN_RST.
  - Any other value sets `err`=1 (sticky until `clr`); the byte is dropped and the block stays in IDLE.
- Load frame fields, all big-endian: ADDR_H, ADDR_L (start address), CNT_H, CNT_L (word count), then per word DATA_H, DATA_L.
- Word count = 0: CNT_L returns to IDLE; no write occurs.
- WRITE state, entered the cycle after DATA_L is accepted:
  - The selected `ext_*_we` = 1 for exactly one cycle, with the registered address and data.
  - The other target's `we` stays 0.
  - Then address += 1 (wraps 0xFFFF→0x0000) and remaining -= 1.
  - Remaining = 0 → IDLE; otherwise → DATA_H.
- `ext_*_addr` / `ext_*_data` hold their last value when `we` = 0. Both targets may share one internal address/data register.
- RUN_RST: `test_normal`=1, `cpu_clr`=1 (one cycle), `run_cycles` cleared to 0; then → RUN.
- RUN:
  - `test_normal`=1.
  - `run_cycles` increments every cycle and saturates at 0xFFFFFFFF.
  - When `cpu_done`=0 is sampled: next cycle `run_done`=1 (one cycle), `test_normal`=0, → IDLE.
  - `run_cycles` holds its value until the next RUN_RST.
- `test_normal`=0 in every state except RUN_RST and RUN, so the core never executes during loading.

## Timing
- Reset (`clr`=1 at an edge) → state IDLE. All outputs are 0: `test_normal`, `cpu_clr`, both `we`, all addresses and data, `busy`, `err`, `run_done`, `run_cycles`. `in_ready` is 1 from the first cycle after `clr` deasserts.
- `clr` mid-frame or mid-RUN aborts immediately. No write strobe and no `run_done` issues on or after the reset edge.
- Write latency: `we` is high in the cycle after the DATA_L accept edge. Peak rate is 1 word per 3 cycles (DATA_H, DATA_L, WRITE).
- `cpu_done` sampled 0 already in the first RUN cycle → `run_done` the next cycle, with `run_cycles`=1.
- `busy` = (state != IDLE), registered with the state.
- In IDLE, `in_valid` held high with bytes back-to-back: one byte is consumed per cycle in the header and field states.

## Test plan
- Reset, then stream A5 00 10 00 02 12 34 AB CD → `ext_instr_we` pulses twice: (0x0010, 0x1234), then (0x0011, 0xABCD). `ext_data_we` stays 0. `busy` returns to 0.
- Stream 5A FF FF 00 02 00 01 00 02 → data writes at 0xFFFF (0x0001) and then 0x0000 (0x0002), showing address wrap.
- Stream 5A 00 00 00 00 → no write strobes; IDLE after 5 accepts. Next, byte 0x77 → `err`=1 and stays 1 through a subsequent valid A5 frame until `clr`.
- Stream 3C with `cpu_done`=1 for 10 RUN cycles, then 0 → `cpu_clr` pulses once and `test_normal`=1 throughout RUN. `run_done` pulses and `run_cycles`=11 (the 10 cycles plus the cycle in which 0 is sampled). `test_normal` returns to 0.
- Toggle `in_valid` randomly during a 4-word instruction frame → exactly 4 writes with correct address and data. `in_ready`=0 in each WRITE cycle.
- Assert `clr` between DATA_H and DATA_L, and separately during RUN → no further `we` or `run_done`; all outputs read 0 the cycle after.
